// File: rtl/basic_boolean_pkg.sv
// Shared types, widths and golden-response function for the basic_boolean exerciser.
package basic_boolean_pkg;

    localparam int unsigned BB_WIDTH = 8;
    localparam logic [BB_WIDTH-1:0] BB_ALL_ONES = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } bb_state_e;

    // AND-reduce broadcast: all ones only when every input bit is set.
    function automatic logic [BB_WIDTH-1:0] bb_expect(input logic [BB_WIDTH-1:0] x);
        return (x == BB_ALL_ONES) ? BB_ALL_ONES : '0;
    endfunction

endpackage

// File: rtl/basic_boolean_expect.sv
// Combinational golden model of the basic_boolean AND-reduce/broadcast block.
module basic_boolean_expect
    import basic_boolean_pkg::*;
(
    input  logic [0:BB_WIDTH-1] vec,
    output logic [0:BB_WIDTH-1] expected
);

    assign expected = bb_expect(vec);

endmodule

// File: rtl/basic_boolean_exerciser.sv
// Sweeps all 256 stimulus vectors into basic_boolean and checks each response.
// Optional BASIC_BOOLEAN_EXERCISER_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module basic_boolean_exerciser
    import basic_boolean_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [0:BB_WIDTH-1] resp,
    output logic [0:BB_WIDTH-1] stim,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [8:0]          err_count,
    output logic [0:BB_WIDTH-1] first_fail
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [8:0] ERR_MAX     = 9'd256;

    bb_state_e           state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [0:BB_WIDTH-1] stim_q, stim_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [8:0]          err_q, err_d;
    logic [0:BB_WIDTH-1] ff_q, ff_d;

    logic [0:BB_WIDTH-1] expected;
    logic                mismatch;
    logic                last_vec;

    basic_boolean_expect u_expect (
        .vec      (stim_q),
        .expected (expected)
    );

    assign mismatch = (resp != expected);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stim_d   = stim_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        ff_d     = ff_q;
        last_vec = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StSettle;
                    cnt_d   = SETTLE_LOAD;
                    stim_d  = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StSettle: begin
                if (cnt_q == 4'd0) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StSample: begin
                if (mismatch) begin
                    err_d = (err_q == ERR_MAX) ? err_q : err_q + 9'd1;
                    if (err_q == 9'd0) begin
                        ff_d = stim_q;
                    end
                end
`ifdef BASIC_BOOLEAN_EXERCISER_STOP_ON_FAIL_EN
                last_vec = (stim_q == BB_ALL_ONES) || mismatch;
`else
                last_vec = (stim_q == BB_ALL_ONES);
`endif
                if (last_vec) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 9'd0);
                end else begin
                    state_d = StSettle;
                    cnt_d   = SETTLE_LOAD;
                    stim_d  = stim_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
        end
    end

    assign stim       = stim_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_basic_boolean_exerciser.sv
// Randomised sweeps of basic_boolean_exerciser against a scoreboard of expected sweep results.
module tb_basic_boolean_exerciser;

    localparam int unsigned S      = 2;
    localparam int unsigned PERIOD = S + 1;
    localparam int unsigned FULL   = 256 * PERIOD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [0:7] resp;
    logic [0:7] stim;
    logic       busy;
    logic       done;
    logic       pass;
    logic [8:0] err_count;
    logic [0:7] first_fail;

    // Per-vector XOR applied to the ideal block's response; nonzero means a faulty DUT.
    logic [7:0] mask [256];

    typedef struct {
        int unsigned acc;
        int unsigned dur;
        int unsigned pass;
        int unsigned err;
        int unsigned ff;
        int unsigned last_stim;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned passes = 0;
    bit          active = 1'b0;
    int unsigned cur_acc = 0;
    int unsigned cur_dur = 0;
    logic        done_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ideal(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : 8'h00;
    endfunction

    assign resp = ideal(stim) ^ mask[stim];

    basic_boolean_exerciser #(
        .SETTLE (S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .resp       (resp),
        .stim       (stim),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Expected sweep outcome from the device-level response table.
    function automatic exp_t model(input int unsigned acc);
        exp_t        e;
        int unsigned count = 0;
        int          first = -1;
        for (int v = 0; v < 256; v++) begin
            logic [7:0] r;
            logic [7:0] want;
            r    = ideal(8'(v)) ^ mask[v];
            want = (v == 255) ? 8'hFF : 8'h00;
            if (r != want) begin
                count++;
                if (first < 0) first = v;
            end
        end
        e.acc = acc;
`ifdef BASIC_BOOLEAN_EXERCISER_STOP_ON_FAIL_EN
        if (count > 0) begin
            e.err       = 1;
            e.dur       = (first + 1) * PERIOD;
            e.last_stim = first;
        end else begin
            e.err       = 0;
            e.dur       = FULL;
            e.last_stim = 255;
        end
`else
        e.err       = (count > 256) ? 256 : count;
        e.dur       = FULL;
        e.last_stim = 255;
`endif
        e.pass = (e.err == 0) ? 1 : 0;
        e.ff   = (first < 0) ? 0 : first;
        return e;
    endfunction

    task automatic set_mask(input int unsigned kind);
        for (int v = 0; v < 256; v++) begin
            case (kind)
                0: mask[v] = 8'h00;
                1: mask[v] = (v == 255) ? 8'hFF : 8'h00;
                2: mask[v] = 8'hFF;
                default: mask[v] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            endcase
        end
    endtask

    task automatic accept(input bit hold, output exp_t e);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        e = model(cyc);
        q.push_back(e);
        cur_acc = cyc;
        cur_dur = e.dur;
        active  = 1'b1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (q.size() != 0 && n < FULL + 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            $display("FAIL sweep_timeout: done not seen, %0d sweeps pending", q.size());
            q.delete();
            active = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_stim"}, stim, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_first_fail"}, first_fail, 0);
    endtask

    // Monitor: stimulus progression while busy, and result scoreboard on done rising.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (active && (cyc - cur_acc) < cur_dur) begin
                check("stim_step", stim, (cyc - cur_acc) / PERIOD);
                check("busy_in_sweep", busy, 1);
            end
            if (done && !done_prev) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL done_unexpected: done rose with no sweep pending (cycle %0d)", cyc);
                end else begin
                    e      = q.pop_front();
                    active = 1'b0;
                    check("sweep_cycles", cyc - e.acc, e.dur);
                    check("pass", pass, e.pass);
                    check("err_count", err_count, e.err);
                    check("first_fail", first_fail, e.ff);
                    check("final_stim", stim, e.last_stim);
                    check("busy_after_done", busy, 0);
                end
            end
        end
        done_prev = done;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e1;
        exp_t        e2;
        int unsigned n;

        set_mask(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        // Ideal, tied-low and fully inverted responders.
        for (int k = 0; k < 3; k++) begin
            set_mask(k);
            accept(1'b0, e1);
            wait_idle();
        end

        // Start pulsed mid-sweep must not disturb anything.
        set_mask(3);
        accept(1'b0, e1);
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Asynchronous reset at vector 0x40, then a fresh sweep.
        set_mask(3);
        accept(1'b0, e1);
        n = 0;
        while (stim != 8'h40 && n < FULL) begin
            @(negedge clk);
            n++;
        end
        check("reached_vec_40", stim, 8'h40);
        rst_n  = 1'b0;
        active = 1'b0;
        #1;
        check_reset_values("midreset");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        set_mask(3);
        accept(1'b0, e1);
        wait_idle();

        // Start held high: DONE restarts on the very next edge.
        set_mask(3);
        accept(1'b1, e1);
        n = 0;
        while (cyc != e1.acc + e1.dur + 1 && n < FULL + 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        e2 = model(cyc);
        q.push_back(e2);
        cur_acc = cyc;
        cur_dur = e2.dur;
        active  = 1'b1;
        start   = 1'b0;
        check("b2b_restart_busy", busy, 1);
        wait_idle();

        for (int k = 0; k < 2; k++) begin
            set_mask(3);
            accept(1'b0, e1);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
